// File: rtl/deser_pkg.sv
// Shared definitions for the serial receiver: aligner state encoding and default parameters.
package deser_pkg;
    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] SYNC_WORD_DEF  = 8'hBC;
    localparam int         MAX_GAP_DEF    = 64;
    localparam int         FIFO_DEPTH_DEF = 4;
endpackage

// File: rtl/deser_fifo.sv
// First-word-fall-through output buffer; drops incoming words when full and flags it sticky.
module deser_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_ready,
    output logic [DW-1:0] o_rdata,
    output logic          o_valid,
    output logic          o_overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_ready && !w_empty;
    // A pop on the same edge frees the slot, so a full FIFO can still accept
    assign w_wr    = i_push && (!w_full || w_pop);

    always_ff @(posedge clk_in) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_push && !w_wr) r_overflow <= 1'b1;
        end
    end

    assign o_valid    = !w_empty;
    assign o_rdata    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_overflow = r_overflow;
endmodule

// File: rtl/deser_rx.sv
// Serial-to-parallel receiver: LSB-first shifter, sync-word aligner (HUNT/LOCKED) and output FIFO.
module deser_rx
    import deser_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD  = SYNC_WORD_DEF,
    parameter int         MAX_GAP    = MAX_GAP_DEF,
    parameter int         FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       en,
    input  logic       ser_data,
    input  logic       data_ready,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       locked,
    output logic       overflow
);
    localparam int GW = $clog2(MAX_GAP + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic [2:0]    r_bit_cnt;
    logic [GW-1:0] r_gap;
    logic [GW-1:0] w_gap_inc;
    logic          w_word_done;
    logic          w_is_sync;
    logic          w_gap_hit;
    logic          w_push;

    assign w_shift_nxt = {ser_data, r_shift[7:1]};
    assign w_is_sync   = (w_shift_nxt == SYNC_WORD);
    assign w_word_done = en && (r_state == ST_LOCKED) && (r_bit_cnt == 3'd7);
    assign w_gap_inc   = r_gap + 1'b1;
    assign w_gap_hit   = (w_gap_inc == GW'(MAX_GAP));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) r_state <= ST_HUNT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = ST_HUNT;
        end else begin
            case (r_state)
                ST_HUNT:   if (w_is_sync) w_state_nxt = ST_LOCKED;
                ST_LOCKED: if (w_word_done && !w_is_sync && w_gap_hit) w_state_nxt = ST_HUNT;
                default:   w_state_nxt = ST_HUNT;
            endcase
        end
    end

    always_comb begin
        locked = (r_state == ST_LOCKED);
        w_push = w_word_done && !w_is_sync;
    end

    // Counters sit at zero throughout HUNT, so they are already cleared on the lock edge
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
            r_gap     <= '0;
        end else if (!en) begin
            r_bit_cnt <= 3'd0;
            r_gap     <= '0;
        end else begin
            r_shift <= w_shift_nxt;
            if (r_state == ST_HUNT) begin
                r_bit_cnt <= 3'd0;
                r_gap     <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (w_word_done) r_gap <= w_is_sync ? '0 : w_gap_inc;
            end
        end
    end

    deser_fifo #(.DW(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_wdata   (w_shift_nxt),
        .i_ready   (data_ready),
        .o_rdata   (data_out),
        .o_valid   (data_valid),
        .o_overflow(overflow)
    );
endmodule

// File: tb/tb_deser_rx.sv
// Directed bench for deser_rx: scoreboard queue fed by stimulus, drained by a data-output monitor.
module tb_deser_rx;
    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       en;
    logic       ser_data;
    logic       data_ready;
    logic [7:0] data_out;
    logic       data_valid;
    logic       locked;
    logic       overflow;
    logic [7:0] g_data_out;
    logic       g_data_valid;
    logic       g_locked;
    logic       g_overflow;

    int         vectors    = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];

    deser_rx dut (
        .clk_in(clk_in), .rst_n(rst_n), .en(en), .ser_data(ser_data),
        .data_ready(data_ready), .data_out(data_out), .data_valid(data_valid),
        .locked(locked), .overflow(overflow)
    );

    // Short-gap instance for the lock-drop scenario
    deser_rx #(.MAX_GAP(4)) dut_g (
        .clk_in(clk_in), .rst_n(rst_n), .en(en), .ser_data(ser_data),
        .data_ready(data_ready), .data_out(g_data_out), .data_valid(g_data_valid),
        .locked(g_locked), .overflow(g_overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        en       = 1'b1;
        ser_data = b;
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; ser_data = 1'b0; data_ready = 1'b1;
        fork
            forever begin
                @(negedge clk_in);
                if (data_valid && data_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL sb_unexpected: got %0h expected no word at %0t", data_out, $time);
                    end else begin
                        chk("sb_word", data_out, exp_q.pop_front());
                    end
                end
            end
        join_none

        // Reset state
        #12;
        chk("rst_valid", data_valid, 0);
        chk("rst_data", data_out, 8'h00);
        chk("rst_locked", locked, 0);
        chk("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        @(posedge clk_in); #1;

        // Lock on the 8th sync bit, then one data word with 1-cycle latency
        for (int i = 0; i < 7; i++) send_bit(1'(8'hBC >> i));
        chk("t1_prelock", locked, 0);
        send_bit(1'b1);
        chk("t1_lock", locked, 1);
        chk("t1_sync_hidden", data_valid, 0);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A);
        chk("t1_valid", data_valid, 1);
        chk("t1_data", data_out, 8'h5A);
        idle(3);

        // Sync at a 3-bit offset
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int i = 0; i < 7; i++) send_bit(1'(8'hBC >> i));
        chk("t2_prelock", locked, 0);
        send_bit(1'b1);
        chk("t2_lock", locked, 1);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_byte(8'h11);
        send_byte(8'h22);
        idle(3);

        // Overflow: 5 words into a depth-4 FIFO with no consumer
        data_ready = 1'b0;
        send_byte(8'hBC);
        for (int w = 1; w <= 5; w++) send_byte(8'(w));
        for (int w = 1; w <= 4; w++) exp_q.push_back(8'(w));
        en = 1'b0;
        chk("t3_ovf", overflow, 1);
        chk("t3_head", data_out, 8'h01);
        data_ready = 1'b1;
        idle(6);
        chk("t3_drained", data_valid, 0);
        chk("t3_ovf_sticky", overflow, 1);

        // Full FIFO with a pop on the edge a further word completes
        rst_n = 1'b0;
        #2;
        chk("t4_rst_ovf", overflow, 0);
        rst_n = 1'b1;
        @(posedge clk_in); #1;
        data_ready = 1'b0;
        send_byte(8'hBC);
        for (int w = 1; w <= 4; w++) send_byte(8'hA0 + 8'(w));
        chk("t4_full_noovf", overflow, 0);
        for (int w = 1; w <= 5; w++) exp_q.push_back(8'hA0 + 8'(w));
        for (int i = 0; i < 7; i++) send_bit(1'(8'hA5 >> i));
        data_ready = 1'b1;
        send_bit(1'(8'hA5 >> 7));
        data_ready = 1'b0;
        en = 1'b0;
        chk("t4_ovf", overflow, 0);
        chk("t4_head", data_out, 8'hA2);
        data_ready = 1'b1;
        idle(6);
        chk("t4_drained", data_valid, 0);

        // Gap limit of 4 on dut_g; default instance keeps all words
        send_byte(8'hBC);
        for (int w = 1; w <= 5; w++) begin
            exp_q.push_back(8'h30 + 8'(w));
            send_byte(8'h30 + 8'(w));
            if (w <= 4) begin
                chk("t5_g_valid", g_data_valid, 1);
                chk("t5_g_data", g_data_out, 8'h30 + 8'(w));
                chk("t5_g_locked", g_locked, (w < 4) ? 1 : 0);
            end else begin
                chk("t5_g_fifth_hidden", g_data_valid, 0);
            end
        end
        send_byte(8'hBC);
        chk("t5_g_relock", g_locked, 1);
        exp_q.push_back(8'h66);
        send_byte(8'h66);
        chk("t5_g_after_sync", g_data_out, 8'h66);
        idle(3);

        // Reset mid-word with two words buffered
        data_ready = 1'b0;
        send_byte(8'hBC);
        send_byte(8'h41);
        send_byte(8'h42);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid_drop", data_valid, 0);
        chk("t6_locked_drop", locked, 0);
        @(negedge clk_in);
        rst_n = 1'b1;
        @(posedge clk_in); #1;
        data_ready = 1'b1;
        send_byte(8'h77);
        chk("t6_no_out", data_valid, 0);
        chk("t6_no_lock", locked, 0);
        send_byte(8'hBC);
        exp_q.push_back(8'h99);
        send_byte(8'h99);
        idle(4);

        chk("sb_all_seen", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/deser_rx.md
DESER_RX -- requirements
Module: deser_rx

Interface
REQ-001 SYNC_WORD, 8'hBC, alignment pattern that marks a word boundary; sync words are never delivered as data.
REQ-002 MAX_GAP, 64, number of consecutive non-sync words tolerated in LOCKED before lock is dropped.
REQ-003 FIFO_DEPTH, 4, output buffer depth in words (power of two, at least 2).
REQ-004 clk_in  input  1  serial bit clock; one data bit per rising edge (SDR); this is the only clock.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  receive enable; low stops reception and returns the aligner to HUNT.
REQ-007 ser_data  input  1  serial data; LSB of each 8-bit word arrives first.
REQ-008 data_out  output  8  head-of-FIFO word, bit 0 = first received bit.
REQ-009 data_valid  output  1  data_out holds a valid word.
REQ-010 data_ready  input  1  consumer accepts data_out on an edge where data_valid and data_ready are both high.
REQ-011 locked  output  1  high in LOCKED state.
REQ-012 overflow  output  1  sticky; a word was dropped because the FIFO was full.

Function
REQ-013 The block SHALL shift ser_data into an 8-bit register on every rising edge with en high, new bit entering at bit 7, so that after 8 edges bit 0 holds the first bit.
REQ-014 The FSM SHALL have exactly two states, HUNT and LOCKED, and SHALL reset to HUNT.
REQ-015 In HUNT, on the edge where the post-shift register value equals SYNC_WORD, the FSM SHALL enter LOCKED and clear the bit counter (0..7) and the gap counter.
REQ-016 In LOCKED, the bit counter SHALL increment each enabled edge and wrap 7->0; the edge on which it wraps completes a word.
REQ-017 A completed word equal to SYNC_WORD SHALL clear the gap counter and SHALL NOT be pushed.
REQ-018 A completed non-sync word SHALL be pushed into the FIFO and SHALL increment the gap counter.
REQ-019 If the gap counter reaches MAX_GAP on a non-sync word, that word SHALL still be pushed and the FSM SHALL then return to HUNT.
REQ-020 en low SHALL force HUNT and clear the bit and gap counters on the next edge; the FIFO contents and the overflow flag SHALL be preserved.
REQ-021 The FIFO SHALL be first-word-fall-through: a word pushed into an empty FIFO on edge k SHALL appear on data_out with data_valid high after edge k (1-cycle latency from the last bit).
REQ-022 data_valid SHALL equal FIFO non-empty, and data_out SHALL hold stable while data_valid is high and data_ready is low.
REQ-023 A simultaneous push and pop on a full FIFO SHALL succeed with the count unchanged and no overflow.
REQ-024 A push on a full FIFO without a pop SHALL drop the new word, leave stored words intact, and set overflow until reset.
REQ-025 A pop on an empty FIFO SHALL have no effect.
REQ-026 The FIFO pointers SHALL wrap modulo FIFO_DEPTH and the count SHALL be held in log2(FIFO_DEPTH)+1 bits.

Reset
REQ-027 rst_n low SHALL immediately, asynchronously, set: state HUNT, shift register 8'h00, bit and gap counters 0, FIFO empty, data_out 8'h00, data_valid 0, locked 0, overflow 0.
REQ-028 Reset mid-word or mid-transfer SHALL discard all partial and buffered data; the first valid word after deassertion requires a new SYNC_WORD.

Structure
REQ-029 State encoding and the default SYNC_WORD constant SHALL reside in the shared package deser_pkg.
REQ-030 The output buffer SHALL be a separate sub-module named deser_fifo; the aligner FSM and shift logic SHALL stay in deser_rx.

Verification
REQ-031 Reset, en=1, stream 0xBC then 0x5A, both LSB first: locked rises on the 8th bit edge; data_out=0x5A with data_valid=1 one edge after its 8th bit; 0xBC is never output.
REQ-032 In HUNT, random bits containing 0xBC at a 3-bit offset: lock on that exact edge; the subsequent 0x11, 0x22 are output in order.
REQ-033 data_ready=0, send sync then 5 data words 0x01..0x05: FIFO holds 0x01..0x04, overflow=1; draining yields 0x01..0x04 only.
REQ-034 FIFO full, data_ready=1 on the edge a 6th word completes: word accepted, no overflow, count stays at 4.
REQ-035 MAX_GAP=4, sync then 5 data words: all 4 words are output, locked falls after the 4th; the 5th is not output until a new 0xBC arrives.
REQ-036 rst_n pulsed low mid-word with 2 words buffered: data_valid drops immediately; after release, no output until a new sync word.
